// File: rtl/dmem_responder.sv
// Data-memory responder for the 64-bit MIPS store/load port: word/doubleword stores,
// combinational loads, post-reset zero-clear sequencer, and a registered debug port.
module dmem_responder #(
  parameter int DEPTH_LOG2 = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  memwrite,
  input  logic [63:0] dataadr,
  input  logic [63:0] writedata,
  output logic [63:0] readdata,
  output logic        ready,
  input  logic [7:0]  addr,
  output logic [31:0] memdata,
  output logic [31:0] storecnt,
  output logic        err
);
  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic {CLEAR, RUN} state_t;

  state_t                state, state_nxt;
  logic [DEPTH_LOG2-1:0] clr_idx, idx, dbg_idx;
  logic [63:0]           mem [DEPTH];
  logic                  in_range, dw_ok, w_ok, accept, bad;

  assign idx      = dataadr[DEPTH_LOG2+2:3];
  assign in_range = (dataadr >> (DEPTH_LOG2 + 3)) == 64'd0;
  assign dw_ok    = (memwrite == 2'b11) && (dataadr[2:0] == 3'd0) && in_range;
  assign w_ok     = (memwrite == 2'b01) && (dataadr[1:0] == 2'd0) && in_range;
  assign dbg_idx  = DEPTH_LOG2'(addr[7:1]);

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    bad       = 1'b0;
    ready     = 1'b0;
    case (state)
      CLEAR: begin
        if (&clr_idx) state_nxt = RUN;
        bad = memwrite != 2'b00;
      end
      RUN: begin
        ready  = 1'b1;
        accept = dw_ok | w_ok;
        bad    = (memwrite != 2'b00) && !(dw_ok | w_ok);
      end
      default: state_nxt = CLEAR;
    endcase
  end

  assign readdata = (state == RUN && in_range) ? mem[idx] : 64'd0;

  // Array has no reset; its contents are defined only by the clear sequencer.
  always_ff @(posedge clk) begin
    if (state == CLEAR)
      mem[clr_idx] <= 64'd0;
    else if (dw_ok)
      mem[idx] <= writedata;
    else if (w_ok) begin
      if (dataadr[2]) mem[idx][63:32] <= writedata[31:0];
      else            mem[idx][31:0]  <= writedata[31:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= CLEAR;
      clr_idx  <= '0;
      memdata  <= 32'd0;
      storecnt <= 32'd0;
      err      <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == CLEAR) clr_idx <= clr_idx + 1'b1;
      // Samples the array before this edge's store lands (read-before-write).
      if (state == RUN)
        memdata <= addr[0] ? mem[dbg_idx][63:32] : mem[dbg_idx][31:0];
      else
        memdata <= 32'd0;
      if (accept && storecnt != 32'hFFFF_FFFF) storecnt <= storecnt + 32'd1;
      if (bad) err <= 1'b1;
    end
  end
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Data-memory responder for the 64-bit MIPS core's store/load port. It is the target end of the memwrite/dataadr/writedata/readdata interface.
- Accepts word and doubleword stores and returns load data combinationally.
- After every reset it zero-clears its array with an internal sequencer.
- Exposes a registered 32-bit debug read port, a store counter and a sticky error flag for bench and board checking.

Parameters:
DEPTH_LOG2, 8, log2 of number of 64-bit entries (default 256 entries = 2048 bytes)

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset
memwrite  input  2  store command: 00 none, 01 word store, 11 doubleword store, 10 illegal
dataadr  input  64  byte address for load and store
writedata  input  64  store data; word store uses bits [31:0]
readdata  output  64  load data for dataadr, combinational
ready  output  1  high once post-reset clear is complete
addr  input  8  debug 32-bit word index (byte address = addr*4)
memdata  output  32  debug read data for addr, registered
storecnt  output  32  count of accepted stores, saturating
err  output  1  sticky error flag

Behaviour:
- Reset (reset=0, asynchronous):
  - FSM goes to CLEAR and the clear index goes to 0.
  - ready=0, memdata=0, storecnt=0, err=0.
  - readdata=0 while in CLEAR.
  - Array contents are undefined until the clear completes.
- FSM CLEAR:
  - Writes 64'h0 to entry[idx] each cycle and increments idx.
  - When idx=2^DEPTH_LOG2-1 is written, the FSM moves to RUN the next cycle and ready rises.
  - Clear takes exactly 2^DEPTH_LOG2 rising edges after reset release.
- FSM RUN: the terminal state; it is left only via reset.
- Address decode:
  - idx = dataadr[DEPTH_LOG2+2:3].
  - In range iff dataadr < 8*2^DEPTH_LOG2, i.e. all upper bits are 0.
- Load:
  - readdata = entry[idx] when in RUN and in range, else 0.
  - Pure combinational. A store in the same cycle is visible on readdata only after the edge.
- Store acceptance (RUN only, sampled on rising edge):
  - 11 (doubleword): needs dataadr[2:0]=0 and in range; writes all 64 bits.
  - 01 (word): needs dataadr[1:0]=0 and in range.
    - dataadr[2]=0 writes entry[idx][31:0]; dataadr[2]=1 writes entry[idx][63:32].
    - The other half is unchanged (little-endian).
  - Accepted store: storecnt increments by 1, saturating at 32'hFFFF_FFFF.
- Error cases (no array write, storecnt unchanged, err set to 1 and held until reset):
  - memwrite=10.
  - Misaligned store.
  - Out-of-range store.
  - Any nonzero memwrite during CLEAR.
- Debug port:
  - memdata is registered: memdata <= word addr of the array (entry[addr>>1], half selected by addr[0]). 1-cycle latency.
  - addr covers byte addresses 0..1020 only.
  - Read-before-write: a store to the same word on the same edge returns the old value, and the new value the following cycle.
  - During CLEAR, memdata <= 0.
- Reset mid-CLEAR or mid-RUN: the clear restarts from index 0; storecnt and err are cleared.

Test Plan:
- Release reset at t0 with DEPTH_LOG2=8 -> ready=0 for 256 edges, then 1. readdata at dataadr=0 reads 0 throughout; every debug address reads memdata=0 after ready.
- RUN, word store memwrite=01, dataadr=100, writedata=7 -> storecnt=1. readdata with dataadr=96 is 64'h0000_0007_0000_0000. addr=25 gives memdata=7 one cycle later.
- RUN, doubleword store memwrite=11, dataadr=320, writedata=4950 -> readdata at 320 is 4950. addr=80 gives memdata=4950 the next cycle. Driving addr=80 on the store edge returns 0 first, then 4950.
- Doubleword store at dataadr=508 (misaligned), then memwrite=10 at 0, then word store at 2048 (out of range) -> no array change, storecnt unchanged, err=1 and held.
- Assert reset at clear index 100, release -> ready=0 for a full 256 edges again. A store issued during CLEAR sets err=1 and writes nothing.
- 4 accepted stores, then reset -> storecnt=0, err=0. Storecnt preloaded near saturation by a long store loop stays at 32'hFFFF_FFFF.
